cpu5_ifu: RTL and testbench

Parametrised instruction-fetch unit that replaces the core's bare pc/instr coupling.
- Holds a fetch PC and issues sequential requests over a valid/ready instruction-memory channel.
- Responses may arrive with variable latency, always in order; they are buffered in a DEPTH-entry prefetch queue.
- Delivers {pc, instr} to decode through a valid/ready handshake.
- On redirect (branch/jump), flushes the queue and silently discards in-flight stale responses.

---
 rtl/cpu5_ifu.sv | 149 ++++++++++++++
 tb/tb_cpu5_ifu.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu5_ifu.sv
// Instruction-fetch unit: credit-limited sequential fetch, in-order prefetch queue, redirect flush.
// Optional macro CPU5_IFU_BYPASS_EN forwards a response straight to decode when the queue is empty.
module cpu5_ifu #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  output logic            ifu_valid_o,
  input  logic            ifu_ready_i,
  output logic [XLEN-1:0] ifu_pc_o,
  output logic [XLEN-1:0] ifu_instr_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic [1:0] {StBoot, StFetch, StStall} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] q_cnt_q, q_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] deq_pc_q, deq_pc_d;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [CntW:0]   inflight;
  logic            credit_ok, q_empty, q_full;
  logic            req_fire, rsp_keep, bypass, ifu_fire, push, pop;
  logic [XLEN-1:0] redirect_aligned;

  // Outstanding plus buffered entries may never exceed the queue size.
  assign inflight         = {1'b0, out_cnt_q} + {1'b0, q_cnt_q};
  assign credit_ok        = inflight < (CntW + 1)'(DEPTH);
  assign q_empty          = (q_cnt_q == '0);
  assign q_full           = (q_cnt_q == CntW'(DEPTH));
  assign redirect_aligned = redirect_pc_i & ~XLEN'(3);
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_keep         = imem_rsp_valid_i && (drop_cnt_q == '0) && !redirect_valid_i;

`ifdef CPU5_IFU_BYPASS_EN
  assign bypass = rsp_keep && q_empty;
`else
  assign bypass = 1'b0;
`endif

  assign ifu_valid_o = !q_empty || bypass;
  assign ifu_instr_o = !q_empty ? mem_q[rd_ptr_q] : (bypass ? imem_rsp_data_i : '0);
  assign ifu_pc_o    = deq_pc_q;
  assign ifu_fire    = ifu_valid_o && ifu_ready_i;
  assign pop         = ifu_fire && !q_empty;
  assign push        = rsp_keep && !(bypass && ifu_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: if (!credit_ok) state_d = StStall;
      StStall: if (credit_ok) state_d = StFetch;
      default: state_d = StBoot;
    endcase
    if (redirect_valid_i) state_d = StFetch;
  end

  always_comb begin
    imem_req_valid_o = (state_q == StFetch) && credit_ok && !redirect_valid_i;
    imem_req_addr_o  = fetch_pc_q;
  end

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (req_fire)         out_cnt_d = out_cnt_d + CntW'(1);
    if (imem_rsp_valid_i) out_cnt_d = out_cnt_d - CntW'(1);

    drop_cnt_d = drop_cnt_q;
    fetch_pc_d = fetch_pc_q;
    deq_pc_d   = deq_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    q_cnt_d    = q_cnt_q;

    if (redirect_valid_i) begin
      // Everything still in flight belongs to the old stream.
      drop_cnt_d = out_cnt_d;
      fetch_pc_d = redirect_aligned;
      deq_pc_d   = redirect_aligned;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      q_cnt_d    = '0;
    end else begin
      if (imem_rsp_valid_i && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (ifu_fire) deq_pc_d = deq_pc_q + XLEN'(4);
      if (push)     wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      q_cnt_d = q_cnt_q + CntW'(1);
      else if (pop && !push) q_cnt_d = q_cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      q_cnt_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fetch_pc_q <= RESET_PC;
      deq_pc_q   <= RESET_PC;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      q_cnt_q    <= q_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      deq_pc_q   <= deq_pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= imem_rsp_data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && q_full && !pop));
  a_no_spurious_rsp: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(imem_rsp_valid_i && (out_cnt_q == '0)));

endmodule

// File: tb/tb_cpu5_ifu.sv
// Directed bench for cpu5_ifu: per-cycle vector table for streaming/stall, hand sequences for
// redirect, request back-pressure, redirect collisions and mid-stream reset.
module tb_cpu5_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifu_valid;
  logic        ifu_ready;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_instr;

  cpu5_ifu #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h100)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .imem_req_valid_o(imem_req_valid),
    .imem_req_ready_i(imem_req_ready),
    .imem_req_addr_o (imem_req_addr),
    .imem_rsp_valid_i(imem_rsp_valid),
    .imem_rsp_data_i (imem_rsp_data),
    .ifu_valid_o     (ifu_valid),
    .ifu_ready_i     (ifu_ready),
    .ifu_pc_o        (ifu_pc),
    .ifu_instr_o     (ifu_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    bit          rst;
    bit          irdy;
    bit          rrdy;
    bit          rv;
    logic [31:0] addr;
    bit          iv;
    logic [31:0] pc;
  } vec_t;

  pend_t pend[$];
  vec_t  vec[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  int    lat   = 1;

  logic        s_req_v, s_req_rdy, s_ifu_v, s_rsp_v;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_rsp();
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  // Sample outputs mid-cycle, then advance one edge and update the memory model.
  task automatic tick();
    @(negedge clk);
    s_req_v   = imem_req_valid;
    s_req_rdy = imem_req_ready;
    s_addr    = imem_req_addr;
    s_ifu_v   = ifu_valid;
    s_pc      = ifu_pc;
    s_instr   = ifu_instr;
    s_rsp_v   = imem_rsp_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (s_rsp_v && pend.size() > 0) void'(pend.pop_front());
    if (s_req_v && s_req_rdy) pend.push_back('{addr: s_addr, due: cyc + lat - 1});
    drive_rsp();
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifu_ready      = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    chk("rst_ifu_valid", {31'b0, ifu_valid}, 32'd0);
    chk("rst_ifu_pc", ifu_pc, 32'h100);
    chk("rst_ifu_instr", ifu_instr, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic add(input bit rst, input bit irdy, input bit rrdy, input bit rv,
                     input logic [31:0] addr, input bit iv, input logic [31:0] pc);
    vec.push_back('{rst: rst, irdy: irdy, rrdy: rrdy, rv: rv, addr: addr, iv: iv, pc: pc});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    ifu_ready      = 1'b0;

    // Streaming with decode always ready, 1-cycle memory.
    add(1, 1, 1, 0, 32'h100, 0, 32'h100);
    add(0, 1, 1, 1, 32'h100, 0, 32'h100);
    add(0, 1, 1, 1, 32'h104, 0, 32'h100);
    add(0, 1, 1, 1, 32'h108, 1, 32'h100);
    add(0, 1, 1, 1, 32'h10C, 1, 32'h104);
    add(0, 1, 1, 1, 32'h110, 1, 32'h108);
    add(0, 1, 1, 1, 32'h114, 1, 32'h10C);
    // Decode stalled: four fetches fill the credit, then one pop frees one fetch.
    add(1, 0, 1, 0, 32'h100, 0, 32'h100);
    add(0, 0, 1, 1, 32'h100, 0, 32'h100);
    add(0, 0, 1, 1, 32'h104, 0, 32'h100);
    add(0, 0, 1, 1, 32'h108, 1, 32'h100);
    add(0, 0, 1, 1, 32'h10C, 1, 32'h100);
    add(0, 0, 1, 0, 32'h110, 1, 32'h100);
    add(0, 0, 1, 0, 32'h110, 1, 32'h100);
    add(0, 0, 1, 0, 32'h110, 1, 32'h100);
    add(0, 1, 1, 0, 32'h110, 1, 32'h100);
    add(0, 0, 1, 0, 32'h110, 1, 32'h104);
    add(0, 0, 1, 1, 32'h110, 1, 32'h104);
    add(0, 0, 1, 0, 32'h114, 1, 32'h104);
    add(0, 0, 1, 0, 32'h114, 1, 32'h104);

    lat = 1;
    for (int i = 0; i < vec.size(); i++) begin
      if (vec[i].rst) do_reset();
      ifu_ready      = vec[i].irdy;
      imem_req_ready = vec[i].rrdy;
      tick();
      chk($sformatf("v%0d_req_valid", i), {31'b0, s_req_v}, {31'b0, vec[i].rv});
      chk($sformatf("v%0d_req_addr", i), s_addr, vec[i].addr);
      chk($sformatf("v%0d_ifu_valid", i), {31'b0, s_ifu_v}, {31'b0, vec[i].iv});
      chk($sformatf("v%0d_ifu_pc", i), s_pc, vec[i].pc);
      if (vec[i].iv) chk($sformatf("v%0d_ifu_instr", i), s_instr, instr_of(vec[i].pc));
    end

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    ifu_ready = 1'b1;
    tick();
    tick();
    chk("t3_req0_addr", s_addr, 32'h100);
    tick();
    chk("t3_req1_addr", s_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    chk("t3_redir_req_valid", {31'b0, s_req_v}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("t3_new_req_valid", {31'b0, s_req_v}, 32'd1);
    chk("t3_new_req_addr", s_addr, 32'h200);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (s_ifu_v) begin
        found = 1'b1;
        chk("t3_first_pc", s_pc, 32'h200);
        chk("t3_first_instr", s_instr, instr_of(32'h200));
      end
    end
    if (!found) chk("t3_first_delivery_timeout", 32'd0, 32'd1);

    // Request back-pressure, then redirect while the request is pending.
    lat = 1;
    do_reset();
    tick();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t4_hold%0d_valid", k), {31'b0, s_req_v}, 32'd1);
      chk($sformatf("t4_hold%0d_addr", k), s_addr, 32'h100);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    chk("t4_redir_valid", {31'b0, s_req_v}, 32'd0);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    chk("t4_after_valid", {31'b0, s_req_v}, 32'd1);
    chk("t4_after_addr", s_addr, 32'h300);

    // Redirect colliding with a response and a decode handshake.
    do_reset();
    tick();
    tick();
    tick();
    ifu_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick();
    chk("t5_hs_valid", {31'b0, s_ifu_v}, 32'd1);
    chk("t5_hs_pc", s_pc, 32'h100);
    chk("t5_rsp_present", {31'b0, s_rsp_v}, 32'd1);
    chk("t5_redir_req_valid", {31'b0, s_req_v}, 32'd0);
    redirect_valid = 1'b0;
    ifu_ready      = 1'b0;
    tick();
    chk("t5_flushed_valid", {31'b0, s_ifu_v}, 32'd0);
    chk("t5_flushed_pc", s_pc, 32'h400);
    chk("t5_new_req_addr", s_addr, 32'h400);
    tick();
    chk("t5_rsp_cycle_valid", {31'b0, s_ifu_v}, 32'd0);
    ifu_ready = 1'b1;
    tick();
    chk("t5_deliver_valid", {31'b0, s_ifu_v}, 32'd1);
    chk("t5_deliver_pc", s_pc, 32'h400);
    chk("t5_deliver_instr", s_instr, instr_of(32'h400));

    // Asynchronous reset with three entries queued.
    do_reset();
    repeat (5) tick();
    #2;
    chk("t6_pre_ifu_valid", {31'b0, ifu_valid}, 32'd1);
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    pend.delete();
    #1;
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_req_addr", imem_req_addr, 32'h100);
    chk("t6_ifu_valid", {31'b0, ifu_valid}, 32'd0);
    chk("t6_ifu_pc", ifu_pc, 32'h100);
    chk("t6_ifu_instr", ifu_instr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("t6_boot_req_valid", {31'b0, s_req_v}, 32'd0);
    tick();
    chk("t6_restart_valid", {31'b0, s_req_v}, 32'd1);
    chk("t6_restart_addr", s_addr, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
